// File: rtl/sync_fifo_pkg.sv
// Shared constants for the synchronous FIFO and its read-side stream adapter.
//   OBUF_DEPTH : number of entries in the read-side output buffer
//   OBUF_CNT_W : width of the output-buffer occupancy count (holds 0..OBUF_DEPTH)
package sync_fifo_pkg;

    localparam int unsigned OBUF_DEPTH = 2;
    localparam int unsigned OBUF_CNT_W = $clog2(OBUF_DEPTH + 1);

endpackage

// File: rtl/sync_fifo_obuf.sv
// Two-entry output buffer for the FIFO read-side adapter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data into the tail entry
//   push_data  : word to store
//   pop        : retire the head entry
//   head       : current head word (registered storage, no input feedthrough)
//   cnt        : number of entries held, 0..OBUF_DEPTH
module sync_fifo_obuf
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic [OBUF_CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] mem [OBUF_DEPTH];
    logic             wptr;
    logic             rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr <= 1'b0;
            rptr <= 1'b0;
            cnt  <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            // Simultaneous push and pop leaves the count unchanged.
            unique case ({push, pop})
                2'b10:   cnt <= cnt + OBUF_CNT_W'(1);
                2'b01:   cnt <= cnt - OBUF_CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/sync_fifo_rd_stream.sv
// Read-side adapter for the synchronous FIFO: converts the one-cycle-latency
// rd/dout interface into a registered valid/ready stream with a 2-entry
// prefetch buffer (first-word-fall-through, full throughput).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   fifo_empty : FIFO empty flag
//   fifo_dout  : FIFO read data, valid the cycle after fifo_rd
//   fifo_rd    : FIFO read strobe (combinational, depends on m_ready)
//   m_valid    : output word valid (from registers)
//   m_data     : output word (from registers)
//   m_ready    : consumer accepts when m_valid && m_ready
//   buf_cnt    : words held in the output buffer, 0..2
module sync_fifo_rd_stream
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [WIDTH-1:0]      fifo_dout,
    output logic                  fifo_rd,
    output logic                  m_valid,
    output logic [WIDTH-1:0]      m_data,
    input  logic                  m_ready,
    output logic [OBUF_CNT_W-1:0] buf_cnt
);

    logic       inflight;
    logic       pop;
    logic [2:0] committed;

    assign m_valid = (buf_cnt != '0);
    assign pop     = m_valid && m_ready;

    // Slots already promised (held + returning - leaving this cycle); a new
    // read is issued only if its data is guaranteed a free slot on return.
    always_comb begin
        committed = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
        fifo_rd   = !fifo_empty && (committed < 3'(OBUF_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd;
        end
    end

    sync_fifo_obuf #(
        .WIDTH(WIDTH)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (fifo_dout),
        .pop       (pop),
        .head      (m_data),
        .cnt       (buf_cnt)
    );

endmodule

// File: tb/tb_sync_fifo_rd_stream.sv
// Self-checking bench for sync_fifo_rd_stream. A behavioural FIFO (queue with
// one-cycle read latency) drives the adapter; the adapter's buffer is modelled
// as a queue of words it should be holding, and every accepted word is
// compared with the global write order.
module tb_sync_fifo_rd_stream;

    logic       clk;
    logic       rst_n;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic [1:0] buf_cnt;

    sync_fifo_rd_stream #(
        .WIDTH(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .buf_cnt    (buf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cycle = 0;

    logic [7:0] fq[$];    // FIFO contents
    logic [7:0] held[$];  // words the adapter should be holding
    logic [7:0] wlog[$];  // all words written and not yet delivered
    bit         rd_pend;  // a FIFO read was issued in the previous cycle
    bit         wr_en;
    logic [7:0] wr_data;

    int         rd_cnt;
    int         pops;
    int         first_vld;
    bit         vld_s;
    logic [7:0] last_pop;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the
    // FIFO and buffer models just after the rising edge.
    task automatic step();
        bit rd_s;
        bit pop_s;
        bit pop_m;
        int occ;
        logic [7:0] w;
        @(negedge clk);
        pop_m = (held.size() != 0) && m_ready;
        occ   = held.size() + (rd_pend ? 1 : 0) - (pop_m ? 1 : 0);
        check_eq("m_valid", m_valid, held.size() != 0);
        if (held.size() != 0) check_eq("m_data", m_data, held[0]);
        check_eq("buf_cnt", buf_cnt, held.size());
        check_eq("fifo_rd", fifo_rd, !fifo_empty && (occ < 2));
        check_eq("cnt_le_2", buf_cnt <= 2'd2, 1);
        rd_s  = fifo_rd;
        pop_s = m_valid && m_ready;
        vld_s = m_valid;
        if (m_valid && first_vld < 0) first_vld = cycle;
        if (rd_s) rd_cnt++;
        @(posedge clk);
        cycle++;
        #1;
        if (pop_s && held.size() != 0) begin
            w = held.pop_front();
            pops++;
            last_pop = w;
            if (wlog.size() != 0) check_eq("order", w, wlog.pop_front());
            else check_eq("extra_word", 1, 0);
        end
        if (rd_pend) held.push_back(fifo_dout);
        if (rd_s && fq.size() != 0) fifo_dout = fq.pop_front();
        rd_pend = rd_s;
        if (wr_en) begin
            fq.push_back(wr_data);
            wlog.push_back(wr_data);
            wr_en = 1'b0;
        end
        fifo_empty = (fq.size() == 0);
    endtask

    // Asynchronous reset, asserted mid-cycle; FIFO resets alongside.
    task automatic do_reset();
        rst_n = 1'b0;
        fq.delete();
        held.delete();
        wlog.delete();
        rd_pend    = 1'b0;
        wr_en      = 1'b0;
        fifo_empty = 1'b1;
        #1;
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_data", m_data, 0);
        check_eq("rst_buf_cnt", buf_cnt, 0);
        check_eq("rst_fifo_rd", fifo_rd, 0);
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        m_ready = 1'b1;
        while ((fq.size() != 0 || held.size() != 0 || rd_pend) && n < 60) begin
            step();
            n++;
        end
        check_eq("drain_done", (fq.size() == 0 && held.size() == 0 && !rd_pend), 1);
        check_eq("no_loss", wlog.size(), 0);
    endtask

    initial begin
        int n0;
        int run;
        int best;
        int p0;
        rst_n      = 1'b1;
        fifo_empty = 1'b1;
        fifo_dout  = 8'h00;
        m_ready    = 1'b0;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        rd_pend    = 1'b0;
        rd_cnt     = 0;
        pops       = 0;
        first_vld  = -1;
        last_pop   = 8'h00;
        #2;
        do_reset();
        repeat (2) step();

        // Single word latency: write in cycle N, valid in N+3.
        m_ready   = 1'b1;
        first_vld = -1;
        n0        = cycle;
        wr_en     = 1'b1;
        wr_data   = 8'hA5;
        repeat (6) step();
        check_eq("single_latency", first_vld, n0 + 3);
        check_eq("single_data", last_pop, 8'hA5);
        check_eq("single_cnt0", buf_cnt, 0);

        // Streaming with no gaps.
        run  = 0;
        best = 0;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) begin
                wr_en   = 1'b1;
                wr_data = 8'(i);
            end
            step();
            run  = vld_s ? run + 1 : 0;
            best = (run > best) ? run : best;
        end
        check_eq("stream_run", best, 8);
        check_eq("stream_last", last_pop, 8'h07);

        // Backpressure: 8 words, consumer stalled.
        m_ready = 1'b0;
        rd_cnt  = 0;
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h10 + i);
            step();
        end
        repeat (6) step();
        check_eq("bp_rd_pulses", rd_cnt, 2);
        check_eq("bp_buf_cnt", buf_cnt, 2);
        check_eq("bp_fifo_used", fq.size(), 6);
        check_eq("bp_head", m_data, 8'h10);
        m_ready = 1'b1;
        p0 = pops;
        repeat (8) step();
        check_eq("bp_release_pops", pops - p0, 8);
        check_eq("bp_release_last", last_pop, 8'h17);
        drain();

        // Alternating ready with a write every cycle.
        for (int i = 0; i < 60; i++) begin
            m_ready = i[0];
            wr_en   = 1'b1;
            wr_data = 8'($urandom);
            step();
        end
        drain();

        // Fully random traffic.
        for (int i = 0; i < 300; i++) begin
            m_ready = ($urandom_range(0, 2) != 0);
            wr_en   = ($urandom_range(0, 3) != 0);
            wr_data = 8'($urandom);
            step();
        end
        drain();

        // Reset while a read is in flight and the buffer holds data.
        n0 = 0;
        while (!(rd_pend && held.size() != 0) && n0 < 100) begin
            m_ready = ($urandom_range(0, 1) != 0);
            wr_en   = 1'b1;
            wr_data = 8'($urandom_range(0, 255));
            step();
            n0++;
        end
        check_eq("mid_rst_setup", (rd_pend && held.size() != 0), 1);
        #1;
        do_reset();
        m_ready = 1'b1;
        pops    = 0;
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        step();
        wr_en   = 1'b1;
        wr_data = 8'hC3;
        step();
        repeat (6) step();
        check_eq("post_rst_pops", pops, 2);
        check_eq("post_rst_last", last_pop, 8'hC3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
